// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage, valid/ready flow-controlled bitwise gate unit.
// S1 captures the operands and the function select. S2 holds the result
// and its zero/all-ones/parity flags. The accumulator lets a transaction
// use the previous result as operand A.
module logic_gate_pipe #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_chain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_ones,
    output logic             out_parity
);

    localparam int unsigned OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_NAND = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_NOTB = 3'd7
    } op_e;

    // Operand payload held in stage 1.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        op_e              op;
        logic             chain;
    } s1_t;

    s1_t              s1_q;
    logic             s1_valid;
    logic [WIDTH-1:0] acc;

    logic             s2_load;
    logic             s1_load;
    logic             in_fire;
    logic             s1_move;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result_c;

    // Flow control: each stage may load when it is empty or the stage after it frees up.
    always_comb begin
        s2_load  = !out_valid || out_ready;
        s1_load  = !s1_valid || s2_load;
        in_ready = s1_load;
        in_fire  = in_valid && s1_load;
        s1_move  = s1_valid && s2_load;
    end

    // Gate function on the stage-1 operands; chain substitutes the accumulator for A.
    always_comb begin
        op_a     = s1_q.chain ? acc : s1_q.a;
        result_c = '0;
        case (s1_q.op)
            OP_AND:  result_c = op_a & s1_q.b;
            OP_OR:   result_c = op_a | s1_q.b;
            OP_NAND: result_c = ~(op_a & s1_q.b);
            OP_NOR:  result_c = ~(op_a | s1_q.b);
            OP_XOR:  result_c = op_a ^ s1_q.b;
            OP_XNOR: result_c = ~(op_a ^ s1_q.b);
            OP_NOTA: result_c = ~op_a;
            OP_NOTB: result_c = ~s1_q.b;
            default: result_c = '0;
        endcase
    end

    // Stage 1: capture the input on a transfer, empty when it drains with nothing new.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (s1_load) begin
            s1_valid <= in_fire;
            if (in_fire) begin
                s1_q.a     <= in_a;
                s1_q.b     <= in_b;
                s1_q.op    <= op_e'(in_op);
                s1_q.chain <= in_chain;
            end
        end
    end

    // Stage 2: register the result and flags when stage 1 moves forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_zero   <= 1'b0;
            out_ones   <= 1'b0;
            out_parity <= 1'b0;
        end else if (s1_move) begin
            out_valid  <= 1'b1;
            out_result <= result_c;
            out_zero   <= ~|result_c;
            out_ones   <= &result_c;
            out_parity <= ^result_c;
        end else if (s2_load) begin
            out_valid  <= 1'b0;
        end
    end

    // Accumulator follows each result as it leaves stage 1, in acceptance order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc <= '0;
        end else if (s1_move) begin
            acc <= result_c;
        end
    end

endmodule

// File: tb/tb_logic_gate_pipe.sv
// Testbench for logic_gate_pipe: directed steps plus randomized traffic
// checked against a truth-table reference model and an in-order scoreboard.
module tb_logic_gate_pipe;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    // WIDTH=8 instance
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_op = '0;
    logic       in_chain = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] out_result;
    logic       out_zero;
    logic       out_ones;
    logic       out_parity;

    // WIDTH=5 instance
    logic       v5_in_valid = 1'b0;
    logic       v5_in_ready;
    logic [4:0] v5_in_a = '0;
    logic [4:0] v5_in_b = '0;
    logic [2:0] v5_in_op = '0;
    logic       v5_in_chain = 1'b0;
    logic       v5_out_valid;
    logic       v5_out_ready = 1'b1;
    logic [4:0] v5_out_result;
    logic       v5_out_zero;
    logic       v5_out_ones;
    logic       v5_out_parity;

    logic_gate_pipe #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_chain(in_chain),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero),
        .out_ones(out_ones), .out_parity(out_parity)
    );

    logic_gate_pipe #(.WIDTH(5)) dut5 (
        .clk(clk), .rst(rst),
        .in_valid(v5_in_valid), .in_ready(v5_in_ready),
        .in_a(v5_in_a), .in_b(v5_in_b), .in_op(v5_in_op), .in_chain(v5_in_chain),
        .out_valid(v5_out_valid), .out_ready(v5_out_ready),
        .out_result(v5_out_result), .out_zero(v5_out_zero),
        .out_ones(v5_out_ones), .out_parity(v5_out_parity)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];
    logic [7:0] seen[$];
    logic [7:0] acc_m = '0;

    logic [7:0] st_a[$];
    logic [7:0] st_b[$];
    logic [2:0] st_op[$];
    logic       st_ch[$];

    int first_acc;
    int first_out;
    int last_out;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-bit truth table indexed by {a_bit, b_bit}.
    function automatic logic [7:0] gate_ref(input logic [2:0] op, input logic [7:0] a,
                                            input logic [7:0] b);
        logic [3:0] tt [8];
        logic [3:0] row;
        logic [7:0] r;
        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b0101;
        row = tt[op];
        for (int i = 0; i < 8; i++) r[i] = row[{a[i], b[i]}];
        return r;
    endfunction

    task automatic model_accept(input logic [7:0] a, input logic [7:0] b,
                                input logic [2:0] op, input logic ch);
        logic [7:0] r;
        r = gate_ref(op, ch ? acc_m : a, b);
        acc_m = r;
        exp_q.push_back(r);
    endtask

    task automatic check_out();
        logic [7:0] e;
        if (out_valid && out_ready) begin
            chk("result_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("result", 32'(out_result), 32'(e));
                chk("zero_flag", 32'(out_zero), 32'(e == 8'h00));
                chk("ones_flag", 32'(out_ones), 32'(e == 8'hFF));
                chk("parity_flag", 32'(out_parity), 32'($countones(e) % 2));
            end
            seen.push_back(out_result);
        end
    endtask

    function automatic void clear_stim();
        st_a.delete(); st_b.delete(); st_op.delete(); st_ch.delete();
    endfunction

    function automatic void add_stim(input logic [7:0] a, input logic [7:0] b,
                                     input logic [2:0] op, input logic ch);
        st_a.push_back(a); st_b.push_back(b); st_op.push_back(op); st_ch.push_back(ch);
    endfunction

    // vmode: 0 valid always, 1 random. rmode: 0 ready always, 1 toggle, 2 random.
    task automatic run(input int vmode, input int rmode, input int budget);
        int         idx = 0;
        int         cyc = 0;
        int         n;
        logic       tog = 1'b0;
        logic       held = 1'b0;
        logic [7:0] held_val = '0;
        n = st_a.size();
        first_acc = -1; first_out = -1; last_out = -1;
        while ((idx < n || exp_q.size() != 0) && cyc < budget) begin
            in_valid = (idx < n) && (vmode == 0 || $urandom_range(0, 3) != 0);
            if (idx < n) begin
                in_a = st_a[idx]; in_b = st_b[idx]; in_op = st_op[idx]; in_chain = st_ch[idx];
            end else begin
                in_a = 8'($urandom); in_b = 8'($urandom);
                in_op = 3'($urandom); in_chain = 1'($urandom);
            end
            case (rmode)
                0:       out_ready = 1'b1;
                1:       out_ready = tog;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
            tog = ~tog;
            #1;
            if (held) chk("hold_stable", 32'(out_result), 32'(held_val));
            held = out_valid && !out_ready;
            held_val = out_result;
            if (out_valid && out_ready) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
            end
            check_out();
            if (in_valid && in_ready) begin
                if (first_acc < 0) first_acc = cyc;
                model_accept(in_a, in_b, in_op, in_chain);
                idx++;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        chk("run_complete", 32'(idx == n && exp_q.size() == 0), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    initial begin
        logic [7:0] ops_exp [8];
        logic [7:0] chain_exp [3];
        logic [7:0] hold_val;
        int         accepted;

        // Reset state
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_flags", 32'({out_zero, out_ones, out_parity}), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // All eight ops back-to-back, a=C5 b=3A
        ops_exp[0] = 8'h00; ops_exp[1] = 8'hFF; ops_exp[2] = 8'hFF; ops_exp[3] = 8'h00;
        ops_exp[4] = 8'hFF; ops_exp[5] = 8'h00; ops_exp[6] = 8'h3A; ops_exp[7] = 8'hC5;
        clear_stim();
        for (int i = 0; i < 8; i++) add_stim(8'hC5, 8'h3A, 3'(i), 1'b0);
        seen.delete();
        run(0, 0, 40);
        chk("ops_count", 32'(seen.size()), 32'd8);
        for (int i = 0; i < 8 && i < seen.size(); i++) chk("ops_value", 32'(seen[i]), 32'(ops_exp[i]));
        chk("ops_latency", 32'(first_out - first_acc), 32'd2);
        chk("ops_throughput", 32'(last_out - first_out), 32'd7);

        // Async reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_a = 8'h11 + 8'(i); in_b = 8'h22; in_op = 3'd1; in_chain = 1'b0;
            #1;
            if (in_ready) model_accept(in_a, in_b, in_op, in_chain);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("full_out_valid", 32'(out_valid), 32'd1);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'd0);
        chk("async_out_result", 32'(out_result), 32'd0);
        chk("async_flags", 32'({out_zero, out_ones, out_parity}), 32'd0);
        exp_q.delete();
        acc_m = '0;
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            @(negedge clk);
            #1;
            chk("no_stale_result", 32'(out_valid), 32'd0);
        end
        @(negedge clk);

        // Back-pressure: four inputs offered with out_ready low
        clear_stim();
        for (int i = 0; i < 4; i++) add_stim(8'h30 + 8'(i), 8'h0F, 3'd4, 1'b0);
        out_ready = 1'b0;
        accepted = 0;
        hold_val = '0;
        for (int c = 0; c < 6; c++) begin
            in_valid = (accepted < 4);
            in_a = st_a[accepted % 4]; in_b = st_b[accepted % 4];
            in_op = st_op[accepted % 4]; in_chain = st_ch[accepted % 4];
            #1;
            if (c >= 3) chk("bp_hold", 32'(out_result), 32'(hold_val));
            hold_val = out_result;
            if (in_valid && in_ready) begin
                model_accept(in_a, in_b, in_op, in_chain);
                accepted++;
            end
            @(posedge clk);
            @(negedge clk);
        end
        #1;
        chk("bp_accepted", 32'(accepted), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        st_a = st_a[2:3]; st_b = st_b[2:3]; st_op = st_op[2:3]; st_ch = st_ch[2:3];
        seen.delete();
        run(0, 0, 40);
        chk("bp_drain_count", 32'(seen.size()), 32'd4);
        if (seen.size() == 4) begin
            chk("bp_order0", 32'(seen[0]), 32'h3F);
            chk("bp_order3", 32'(seen[3]), 32'h3C);
        end

        // Chain sequence, ready high then toggling
        chain_exp[0] = 8'hFF; chain_exp[1] = 8'h3C; chain_exp[2] = 8'hC3;
        for (int pass = 0; pass < 2; pass++) begin
            clear_stim();
            add_stim(8'h0F, 8'hF0, 3'd1, 1'b0);
            add_stim(8'h00, 8'h3C, 3'd0, 1'b1);
            add_stim(8'h55, 8'hFF, 3'd4, 1'b1);
            seen.delete();
            run(0, pass, 40);
            chk("chain_count", 32'(seen.size()), 32'd3);
            for (int i = 0; i < 3 && i < seen.size(); i++)
                chk("chain_value", 32'(seen[i]), 32'(chain_exp[i]));
        end

        // Randomized traffic with chaining
        clear_stim();
        for (int i = 0; i < 300; i++)
            add_stim(8'($urandom), 8'($urandom), 3'($urandom), ($urandom_range(0, 2) == 0));
        seen.delete();
        run(1, 2, 3000);
        chk("rand_count", 32'(seen.size()), 32'd300);

        // WIDTH=5 parity and all-ones
        v5_out_ready = 1'b1;
        v5_in_valid = 1'b1;
        v5_in_a = 5'h15; v5_in_b = 5'h01; v5_in_op = 3'd4;
        #1;
        chk("w5_in_ready", 32'(v5_in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        v5_in_a = 5'h1F; v5_in_b = 5'h00; v5_in_op = 3'd1;
        @(posedge clk);
        @(negedge clk);
        v5_in_valid = 1'b0;
        #1;
        chk("w5_xor_valid", 32'(v5_out_valid), 32'd1);
        chk("w5_xor_result", 32'(v5_out_result), 32'h14);
        chk("w5_xor_parity", 32'(v5_out_parity), 32'd0);
        chk("w5_xor_zo", 32'({v5_out_zero, v5_out_ones}), 32'd0);
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("w5_or_result", 32'(v5_out_result), 32'h1F);
        chk("w5_or_ones", 32'(v5_out_ones), 32'd1);
        chk("w5_or_parity", 32'(v5_out_parity), 32'd1);
        chk("w5_or_zero", 32'(v5_out_zero), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
